// File: rtl/anita_buffer_pkg.sv
// Shared types and constants for the ANITA LAB buffer hold scheduler.
// Buffer indices, buffer letter names and scheduler FSM state encoding.
package anita_buffer_pkg;

    localparam int NUM_BUFFERS = 4;

    typedef logic [1:0] bufIdx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } schedState_t;

    localparam bufIdx_t BUF_A = 2'd0;
    localparam bufIdx_t BUF_B = 2'd1;
    localparam bufIdx_t BUF_C = 2'd2;
    localparam bufIdx_t BUF_D = 2'd3;

endpackage

// File: rtl/anita_buffer_rr_select.sv
// Round-robin free-buffer finder: first clear hold bit at ptr, ptr+1, ... (mod 4).
module anita_buffer_rr_select
    import anita_buffer_pkg::*;
(
    input  logic [NUM_BUFFERS-1:0] holds_i,
    input  logic [1:0]             ptr_i,
    output logic                   found_o,
    output logic [1:0]             idx_o
);

    // Scan farthest offset first so the closest free buffer to ptr wins.
    always_comb begin
        bufIdx_t cand;
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            cand = ptr_i + 2'(i);
            if (!holds_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/anita_buffer_hold_scheduler.sv
// Allocates LAB buffers to triggers, drives timed digitize requests, tracks holds,
// and keeps saturating deadtime / dropped-trigger housekeeping counters.
module anita_buffer_hold_scheduler
    import anita_buffer_pkg::*;
#(
    parameter int DIGITIZE_WIDTH = 4,
    parameter int HOLDOFF        = 8,
    parameter int DEAD_W         = 32,
    parameter int DROP_W         = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   trig_i,
    input  logic [3:0]             trig_source_i,
    input  logic                   release_i,
    input  logic [1:0]             release_buffer_i,
    input  logic                   clr_all_i,
    output logic                   digitize_o,
    output logic [1:0]             digitize_buffer_o,
    output logic [3:0]             digitize_source_o,
    output logic [NUM_BUFFERS-1:0] buffer_status_o,
    output logic                   full_o,
    output logic [DEAD_W-1:0]      deadtime_o,
    output logic [DROP_W-1:0]      dropped_o,
    output logic                   release_err_o
);

    localparam int TMR_MAX = (DIGITIZE_WIDTH > HOLDOFF) ? DIGITIZE_WIDTH : HOLDOFF;
    localparam int TMR_W   = $clog2(TMR_MAX);

    schedState_t             state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [NUM_BUFFERS-1:0]  holds_q, holds_d;
    bufIdx_t                 ptr_q, ptr_d;
    bufIdx_t                 digBuf_q, digBuf_d;
    logic [3:0]              digSrc_q, digSrc_d;
    logic                    relErr_q, relErr_d;
    logic [DEAD_W-1:0]       deadtime_q, deadtime_d;
    logic [DROP_W-1:0]       dropped_q, dropped_d;

    logic [NUM_BUFFERS-1:0]  holdsAfterClr;
    logic [NUM_BUFFERS-1:0]  holdsAfterRel;
    bufIdx_t                 ptrBase;
    logic                    relErrBase;
    logic                    freeFound;
    logic [1:0]              freeIdx;
    logic                    accept;

    // Clear-all is applied before release so allocation sees the post-release hold set.
    always_comb begin
        holdsAfterClr = clr_all_i ? '0 : holds_q;
        ptrBase       = clr_all_i ? BUF_A : ptr_q;
        relErrBase    = clr_all_i ? 1'b0 : relErr_q;
        holdsAfterRel = holdsAfterClr;
        if (release_i) begin
            if (holdsAfterClr[release_buffer_i]) begin
                holdsAfterRel[release_buffer_i] = 1'b0;
            end else begin
                relErrBase = 1'b1;
            end
        end
    end

    anita_buffer_rr_select u_rr_select (
        .holds_i (holdsAfterRel),
        .ptr_i   (ptrBase),
        .found_o (freeFound),
        .idx_o   (freeIdx)
    );

    assign accept = (state_q == ST_IDLE) && trig_i && freeFound;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        holds_d    = holdsAfterRel;
        ptr_d      = ptrBase;
        digBuf_d   = digBuf_q;
        digSrc_d   = digSrc_q;
        relErr_d   = relErrBase;
        deadtime_d = deadtime_q;
        dropped_d  = dropped_q;

        if (accept) begin
            holds_d[freeIdx] = 1'b1;
            ptr_d            = freeIdx + 2'd1;
            digBuf_d         = freeIdx;
            digSrc_d         = trig_source_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ASSERT;
                    timer_d = TMR_W'(DIGITIZE_WIDTH - 1);
                end
            end
            ST_ASSERT: begin
                if (timer_q == '0) begin
                    state_d = ST_HOLDOFF;
                    timer_d = TMR_W'(HOLDOFF - 1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (full_o && (deadtime_q != '1)) begin
            deadtime_d = deadtime_q + DEAD_W'(1);
        end
        if (trig_i && !accept && (dropped_q != '1)) begin
            dropped_d = dropped_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            holds_q    <= '0;
            ptr_q      <= BUF_A;
            digBuf_q   <= BUF_A;
            digSrc_q   <= '0;
            relErr_q   <= 1'b0;
            deadtime_q <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            holds_q    <= holds_d;
            ptr_q      <= ptr_d;
            digBuf_q   <= digBuf_d;
            digSrc_q   <= digSrc_d;
            relErr_q   <= relErr_d;
            deadtime_q <= deadtime_d;
            dropped_q  <= dropped_d;
        end
    end

    assign digitize_o        = (state_q == ST_ASSERT);
    assign digitize_buffer_o = digBuf_q;
    assign digitize_source_o = digSrc_q;
    assign buffer_status_o   = holds_q;
    assign full_o            = &holds_q;
    assign deadtime_o        = deadtime_q;
    assign dropped_o         = dropped_q;
    assign release_err_o     = relErr_q;

endmodule

// File: tb/tb_anita_buffer_hold_scheduler.sv
// Directed bench for the buffer hold scheduler: scoreboard of expected digitize
// buffer/source pairs plus a small model of deadtime and dropped counts.
module tb_anita_buffer_hold_scheduler;
    import anita_buffer_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        trig_i = 1'b0;
    logic [3:0]  trig_source_i = 4'h0;
    logic        release_i = 1'b0;
    logic [1:0]  release_buffer_i = 2'd0;
    logic        clr_all_i = 1'b0;
    logic        digitize_o;
    logic [1:0]  digitize_buffer_o;
    logic [3:0]  digitize_source_o;
    logic [3:0]  buffer_status_o;
    logic        full_o;
    logic [31:0] deadtime_o;
    logic [15:0] dropped_o;
    logic        release_err_o;

    typedef struct {
        logic [1:0] bufIdx;
        logic [3:0] src;
    } expDig_t;

    expDig_t     sbQ[$];
    int          total = 0;
    int          bad = 0;
    logic        expFull = 1'b0;
    logic [31:0] deadExp = 32'd0;
    logic [15:0] dropExp = 16'd0;
    logic        prevDig = 1'b0;

    anita_buffer_hold_scheduler dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .trig_i            (trig_i),
        .trig_source_i     (trig_source_i),
        .release_i         (release_i),
        .release_buffer_i  (release_buffer_i),
        .clr_all_i         (clr_all_i),
        .digitize_o        (digitize_o),
        .digitize_buffer_o (digitize_buffer_o),
        .digitize_source_o (digitize_source_o),
        .buffer_status_o   (buffer_status_o),
        .full_o            (full_o),
        .deadtime_o        (deadtime_o),
        .dropped_o         (dropped_o),
        .release_err_o     (release_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        if (expFull && (deadExp != 32'hFFFF_FFFF)) deadExp++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic t, input logic [3:0] s, input logic r,
                                 input logic [1:0] rb, input logic c);
        trig_i           = t;
        trig_source_i    = s;
        release_i        = r;
        release_buffer_i = rb;
        clr_all_i        = c;
        tick();
        trig_i    = 1'b0;
        release_i = 1'b0;
        clr_all_i = 1'b0;
    endtask

    task automatic expectDrop();
        if (dropExp != 16'hFFFF) dropExp++;
    endtask

    // Every digitize rising edge consumes one scoreboard entry.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            prevDig = 1'b0;
        end else begin
            if (digitize_o && !prevDig) begin
                checkOutput("dig_expected", 32'(digitize_o), 32'(sbQ.size() != 0));
                if (sbQ.size() != 0) begin
                    expDig_t e;
                    e = sbQ.pop_front();
                    checkOutput("sb_buffer", 32'(digitize_buffer_o), 32'(e.bufIdx));
                    checkOutput("sb_source", 32'(digitize_source_o), 32'(e.src));
                end
            end
            prevDig = digitize_o;
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_dig", 32'(digitize_o), 32'd0);
        checkOutput("rst_status", 32'(buffer_status_o), 32'd0);
        checkOutput("rst_full", 32'(full_o), 32'd0);
        checkOutput("rst_dead", deadtime_o, 32'd0);
        checkOutput("rst_drop", 32'(dropped_o), 32'd0);
        checkOutput("rst_err", 32'(release_err_o), 32'd0);
        checkOutput("rst_buf", 32'(digitize_buffer_o), 32'd0);
        checkOutput("rst_src", 32'(digitize_source_o), 32'd0);
        rst_n_i = 1'b1;
        tick();

        // First trigger: one-cycle latency, four-cycle digitize pulse
        sbQ.push_back('{BUF_A, 4'h5});
        applyStimulus(1'b1, 4'h5, 1'b0, 2'd0, 1'b0);
        checkOutput("t1_dig_rise", 32'(digitize_o), 32'd1);
        checkOutput("t1_status", 32'(buffer_status_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t1_dig_high", 32'(digitize_o), 32'd1);
        end
        tick();
        checkOutput("t1_dig_fall", 32'(digitize_o), 32'd0);
        repeat (16) tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        checkOutput("t1_clr_status", 32'(buffer_status_o), 32'h0);

        // Four spaced triggers fill A..D in order
        for (int i = 0; i < 4; i++) begin
            sbQ.push_back('{2'(i), 4'(i + 1)});
            applyStimulus(1'b1, 4'(i + 1), 1'b0, 2'd0, 1'b0);
            if (i == 3) expFull = 1'b1;
            checkOutput("t2_status", 32'(buffer_status_o), 32'((1 << (i + 1)) - 1));
            repeat (19) tick();
        end
        checkOutput("t2_full", 32'(full_o), 32'd1);
        checkOutput("t2_dead", deadtime_o, deadExp);
        tick();
        checkOutput("t2_dead_inc", deadtime_o, deadExp);

        // Triggers rejected while full, then release+trigger reuses buffer C
        for (int i = 0; i < 3; i++) begin
            expectDrop();
            applyStimulus(1'b1, 4'hE, 1'b0, 2'd0, 1'b0);
            checkOutput("t3_no_dig", 32'(digitize_o), 32'd0);
            tick();
        end
        checkOutput("t3_dropped", 32'(dropped_o), 32'(dropExp));
        sbQ.push_back('{BUF_C, 4'h7});
        applyStimulus(1'b1, 4'h7, 1'b1, 2'd2, 1'b0);
        checkOutput("t3_rel_dig", 32'(digitize_o), 32'd1);
        checkOutput("t3_rel_buf", 32'(digitize_buffer_o), 32'(BUF_C));
        checkOutput("t3_rel_status", 32'(buffer_status_o), 32'hF);

        // Holdoff window: trigger 5 cycles after fall dropped, 8 cycles after accepted
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 1'b0);
        expFull = 1'b0;
        checkOutput("t4_rel_status", 32'(buffer_status_o), 32'hE);
        repeat (8) tick();
        expectDrop();
        applyStimulus(1'b1, 4'h3, 1'b0, 2'd0, 1'b0);
        checkOutput("t4_holdoff_drop", 32'(dropped_o), 32'(dropExp));
        checkOutput("t4_holdoff_status", 32'(buffer_status_o), 32'hE);
        repeat (2) tick();
        sbQ.push_back('{BUF_A, 4'h9});
        applyStimulus(1'b1, 4'h9, 1'b0, 2'd0, 1'b0);
        expFull = 1'b1;
        checkOutput("t4_accept_dig", 32'(digitize_o), 32'd1);
        checkOutput("t4_accept_status", 32'(buffer_status_o), 32'hF);
        repeat (20) tick();

        // Sticky release error
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        expFull = 1'b0;
        checkOutput("t5_clr_status", 32'(buffer_status_o), 32'h0);
        checkOutput("t5_dead", deadtime_o, deadExp);
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd1, 1'b0);
        checkOutput("t5_err_set", 32'(release_err_o), 32'd1);
        repeat (3) tick();
        checkOutput("t5_err_sticky", 32'(release_err_o), 32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        checkOutput("t5_err_clr", 32'(release_err_o), 32'd0);

        // clr_all during ASSERT of buffer D
        for (int i = 0; i < 4; i++) begin
            sbQ.push_back('{2'(i), 4'(10 + i)});
            applyStimulus(1'b1, 4'(10 + i), 1'b0, 2'd0, 1'b0);
            if (i < 3) repeat (19) tick();
        end
        expFull = 1'b1;
        checkOutput("t6_buf_d", 32'(digitize_buffer_o), 32'(BUF_D));
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        expFull = 1'b0;
        checkOutput("t6_clr_status", 32'(buffer_status_o), 32'h0);
        checkOutput("t6_clr_full", 32'(full_o), 32'd0);
        checkOutput("t6_dig_cont", 32'(digitize_o), 32'd1);
        tick();
        checkOutput("t6_dig_last", 32'(digitize_o), 32'd1);
        tick();
        checkOutput("t6_dig_done", 32'(digitize_o), 32'd0);
        repeat (16) tick();
        sbQ.push_back('{BUF_A, 4'h6});
        applyStimulus(1'b1, 4'h6, 1'b0, 2'd0, 1'b0);
        checkOutput("t6_next_status", 32'(buffer_status_o), 32'h1);
        repeat (20) tick();
        sbQ.push_back('{BUF_A, 4'h8});
        applyStimulus(1'b1, 4'h8, 1'b0, 2'd0, 1'b1);
        checkOutput("t6_clr_trig_status", 32'(buffer_status_o), 32'h1);
        repeat (20) tick();

        // Asynchronous reset mid-ASSERT
        sbQ.push_back('{BUF_B, 4'h2});
        applyStimulus(1'b1, 4'h2, 1'b0, 2'd0, 1'b0);
        checkOutput("rst2_pre_status", 32'(buffer_status_o), 32'h3);
        tick();
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("rst2_dig", 32'(digitize_o), 32'd0);
        checkOutput("rst2_status", 32'(buffer_status_o), 32'h0);
        checkOutput("rst2_buf", 32'(digitize_buffer_o), 32'd0);
        checkOutput("rst2_src", 32'(digitize_source_o), 32'd0);
        checkOutput("rst2_drop", 32'(dropped_o), 32'd0);
        checkOutput("rst2_dead", deadtime_o, 32'd0);
        dropExp = 16'd0;
        deadExp = 32'd0;
        expFull = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // Counter saturation
        for (int i = 0; i < 4; i++) begin
            sbQ.push_back('{2'(i), 4'h4});
            applyStimulus(1'b1, 4'h4, 1'b0, 2'd0, 1'b0);
            repeat (19) tick();
        end
        expFull = 1'b1;
        force dut.deadtime_q = 32'hFFFF_FFFD;
        deadExp = 32'hFFFF_FFFD;
        @(negedge clk_i);
        release dut.deadtime_q;
        repeat (3) tick();
        checkOutput("sat_dead", deadtime_o, deadExp);
        force dut.dropped_q = 16'hFFFE;
        dropExp = 16'hFFFE;
        @(negedge clk_i);
        release dut.dropped_q;
        for (int i = 0; i < 2; i++) begin
            expectDrop();
            applyStimulus(1'b1, 4'h1, 1'b0, 2'd0, 1'b0);
            checkOutput("sat_drop", 32'(dropped_o), 32'(dropExp));
        end
        tick();
        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
